id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
// - Decode stage of the 5-stage RV32I pipeline; consumes InstrnD/PCD/PCplus4D from fetch.
// - Decodes the instruction and reads the 32x32 register file.
// - Produces the ID/EX pipeline register feeding execute, which returns PCSrcE/PCTargetE to fetch.
// - Accepts the writeback port (RegWriteW/RdW/ResultW) and the hazard-unit flush (FlushE).
// PARAMETERS
// - XLEN     32  datapath width
// - NREGS    32  architectural registers; x0 hardwired to 0
// PORTS
// clk          in   1     rising-edge clock, only clock
// rst          in   1     synchronous, active-high reset
// InstrnD      in   32    instruction from fetch
// PCD          in   32    PC of InstrnD
// PCplus4D     in   32    PCD+4
// FlushE       in   1     turn next ID/EX contents into a bubble
// RegWriteW    in   1     writeback enable
// RdW          in   5     writeback destination
// ResultW      in   32    writeback data
// RD1E,RD2E    out  32    rs1/rs2 operand values
// ImmExtE      out  32    sign-extended immediate
// PCE,PCplus4E out  32    PC and PC+4 carried forward
// Rs1E,Rs2E,RdE out 5     register indices, for forwarding/hazard unit
// RegWriteE    out  1     writes a register
// ResultSrcE   out  2     00 ALU, 01 memory, 10 PC+4
// MemWriteE    out  1     store
// JumpE        out  1     jal
// BranchE      out  1     beq
// ALUControlE  out  3     000 add, 001 sub, 010 and, 011 or, 101 slt
// ALUSrcE      out  1     0 = RD2, 1 = ImmExt
// BEHAVIOUR
// - All E outputs are registered; latency 1 clk from InstrnD to E outputs.
// - Priority on each rising edge: rst > FlushE > load.
//   - rst: all E outputs = 0; all 32 registers = 0.
//   - FlushE: all E outputs = 0, i.e. a NOP bubble.
//   - load: decoded values.
// - Supported opcodes:
//   - lw 0000011: RegW=1, ResSrc=01, ALUSrc=1, ImmSrc I, add.
//   - sw 0100011: MemW=1, ALUSrc=1, ImmSrc S, add.
//   - R-type 0110011: RegW=1, ALU per funct.
//   - I-ALU 0010011: RegW=1, ALUSrc=1, ImmSrc I, ALU per funct.
//   - beq 1100011: Branch=1, ImmSrc B, sub.
//   - jal 1101111: RegW=1, Jump=1, ResSrc=10, ImmSrc J.
// - ALU decode from funct3:
//   - 000: sub iff opcode=0110011 and funct7[5]=1, else add.
//   - 010: slt.  110: or.  111: and.
//   - Any other funct3 gives add.
// - Any unlisted opcode: all control = 0 and ImmExtE = 0; register indices and PCs still load.
// - Immediates, sign-extended from InstrnD[31]:
//   - I = [31:20]
//   - S = {[31:25],[11:7]}
//   - B = {[31],[7],[30:25],[11:8],0}
//   - J = {[31],[19:12],[20],[30:21],0}
// - Register file:
//   - Write on rising edge when RegWriteW=1 and RdW!=0.
//   - A write to x0 is ignored.
// - Read bypass:
//   - Combinational read returns ResultW when RegWriteW=1, RdW!=0 and RdW equals the read index.
//   - So a same-cycle writeback is seen by the instruction in D.
// - x0 reads 0 regardless of bypass.
// - Writeback during rst: the register is cleared; reset wins.
// - Writeback during FlushE: the write still commits; the flush only affects ID/EX.
// STRUCTURE
// - Shared package rv_pkg:
//   - opcode constants
//   - ALUControl codes
//   - ResultSrc and ImmSrc encodings
//   - XLEN
// - Sub-module reg_file: 2 combinational read ports with write bypass, 1 sync write port, sync reset.
// - Main decoder, ALU decoder and immediate extender are combinational logic inside id_stage.
// TESTING
// 1. rst=1 for 1 clk -> all E outputs 0; reading x1..x31 afterwards gives 0.
// 2. Write x5=0x0000_00AA through the W port, then InstrnD=0x00528313 (addi x6,x5,5):
//    - expected: RD1E=0xAA, ImmExtE=5, ALUSrcE=1, RegWriteE=1, RdE=6, ALUControlE=000.
// 3. RegWriteW=1, RdW=7, ResultW=0x1234 in the same cycle as InstrnD=0x40738433 (sub x8,x7,x7):
//    - expected: RD1E=RD2E=0x1234 (bypass), ALUControlE=001.
// 4. InstrnD=0xFE000EE3 (beq x0,x0,-4) with PCD=0x100:
//    - expected: BranchE=1, ImmExtE=0xFFFF_FFFC, PCE=0x100, ALUControlE=001.
//    - expected: FlushE=1 on the same edge gives all-zero control.
// 5. InstrnD=0x008000EF (jal x1,8): JumpE=1, ResultSrcE=10, ImmExtE=8, RdE=1, PCplus4E=PCplus4D.
// 6. Write x0=0xFFFF via the W port, then read x0 -> 0.
//    - also: InstrnD=0xFFFFFFFF (illegal) -> all control 0, ImmExtE=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, opcodes, control encodings and the
// immediate extender used by the decode stage.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // IMM_NONE covers R-type and unknown opcodes, which carry no immediate
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_e;

    function automatic logic [XLEN-1:0] immExtend(input logic [XLEN-1:0] instr,
                                                  input imm_src_e src);
        case (src)
            IMM_I:   immExtend = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   immExtend = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   immExtend = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   immExtend = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExtend = '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with writeback bypass,
// one synchronous write port, synchronous clear; x0 is hardwired to zero.
module reg_file
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [1:NREGS-1];

    // Reset takes precedence over a writeback arriving on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0)         ? '0 :
                 (we && wa == ra1)     ? wd : regs[ra1];
    assign rd2 = (ra2 == 5'd0)         ? '0 :
                 (we && wa == ra2)     ? wd : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: main/ALU decode, immediate extension, register read,
// and the ID/EX pipeline register with flush-to-bubble.
module id_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrnD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCplus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCplus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1D, rs2D, rdD;
    logic [XLEN-1:0] rd1D, rd2D, immExtD;

    logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD;
    logic            useFunct, forceSub;
    result_src_e     resultSrcD;
    imm_src_e        immSrcD;
    alu_ctl_e        aluCtlD;

    assign opcode = InstrnD[6:0];
    assign funct3 = InstrnD[14:12];
    assign rs1D   = InstrnD[19:15];
    assign rs2D   = InstrnD[24:20];
    assign rdD    = InstrnD[11:7];

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW),
        .ra1 (rs1D),
        .ra2 (rs2D),
        .rd1 (rd1D),
        .rd2 (rd2D)
    );

    // Unknown opcodes fall through with every control bit low and no immediate
    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        jumpD      = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        useFunct   = 1'b0;
        forceSub   = 1'b0;
        resultSrcD = RES_ALU;
        immSrcD    = IMM_NONE;
        case (opcode)
            OP_LW:  begin regWriteD = 1'b1; resultSrcD = RES_MEM; aluSrcD = 1'b1; immSrcD = IMM_I; end
            OP_SW:  begin memWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_S; end
            OP_R:   begin regWriteD = 1'b1; useFunct = 1'b1; end
            OP_I:   begin regWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_I; useFunct = 1'b1; end
            OP_BEQ: begin branchD = 1'b1; immSrcD = IMM_B; forceSub = 1'b1; end
            OP_JAL: begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = RES_PC4; immSrcD = IMM_J; end
            default: ;
        endcase
    end

    // funct7[5] selects sub only for register-register ops; addi ignores it
    always_comb begin
        aluCtlD = ALU_ADD;
        if (forceSub) begin
            aluCtlD = ALU_SUB;
        end else if (useFunct) begin
            case (funct3)
                3'b000:  aluCtlD = (opcode == OP_R && InstrnD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  aluCtlD = ALU_SLT;
                3'b110:  aluCtlD = ALU_OR;
                3'b111:  aluCtlD = ALU_AND;
                default: aluCtlD = ALU_ADD;
            endcase
        end
    end

    assign immExtD = immExtend(InstrnD, immSrcD);

    // Reset and flush both turn the ID/EX register into an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCplus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
        end else begin
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= immExtD;
            PCE         <= PCD;
            PCplus4E    <= PCplus4D;
            Rs1E        <= rs1D;
            Rs2E        <= rs2D;
            RdE         <= rdD;
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            JumpE       <= jumpD;
            BranchE     <= branchD;
            ALUControlE <= aluCtlD;
            ALUSrcE     <= aluSrcD;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: reset behaviour, decode of each opcode
// class, immediates, writeback bypass, x0 handling and flush.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrnD, PCD, PCplus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    int testsRun    = 0;
    int testsFailed = 0;

    // ctl packs {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        flush;
        logic        rwW;
        logic [4:0]  rdW;
        logic [31:0] resW;
        logic        chkImm;
        logic [31:0] rd1, rd2, imm, pce, pc4e;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  ctl;
    } vec_t;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .InstrnD     (InstrnD),
        .PCD         (PCD),
        .PCplus4D    (PCplus4D),
        .FlushE      (FlushE),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCplus4E    (PCplus4E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [31:0] instr, logic [31:0] pcd,
                                logic flush, logic rwW, logic [4:0] rdW, logic [31:0] resW,
                                logic chkImm, logic [31:0] rd1, logic [31:0] rd2,
                                logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [9:0] ctl);
        vec_t v;
        v.name = nm;   v.instr = instr; v.pcd = pcd;   v.flush = flush;
        v.rwW = rwW;   v.rdW = rdW;     v.resW = resW; v.chkImm = chkImm;
        v.rd1 = rd1;   v.rd2 = rd2;     v.imm = imm;
        v.rs1 = rs1;   v.rs2 = rs2;     v.rd = rd;     v.ctl = ctl;
        v.pce  = flush ? 32'd0 : pcd;
        v.pc4e = flush ? 32'd0 : pcd + 32'd4;
        return v;
    endfunction

    function automatic vec_t bubble(vec_t vin);
        vec_t v = vin;
        v.rd1 = '0; v.rd2 = '0; v.imm = '0; v.pce = '0; v.pc4e = '0;
        v.rs1 = '0; v.rs2 = '0; v.rd = '0;  v.ctl = '0; v.chkImm = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] encAdd(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        InstrnD   = v.instr;
        PCD       = v.pcd;
        PCplus4D  = v.pcd + 32'd4;
        FlushE    = v.flush;
        RegWriteW = v.rwW;
        RdW       = v.rdW;
        ResultW   = v.resW;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [9:0] ctl;
        logic       ok;
        ctl = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE};
        ok  = (RD1E === v.rd1) && (RD2E === v.rd2) && (PCE === v.pce) &&
              (PCplus4E === v.pc4e) && (Rs1E === v.rs1) && (Rs2E === v.rs2) &&
              (RdE === v.rd) && (ctl === v.ctl) && (!v.chkImm || ImmExtE === v.imm);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL %s: got rd1=%h rd2=%h imm=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d ctl=%b, expected rd1=%h rd2=%h imm=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d ctl=%b",
                     v.name, RD1E, RD2E, ImmExtE, PCE, PCplus4E, Rs1E, Rs2E, RdE, ctl,
                     v.rd1, v.rd2, v.imm, v.pce, v.pc4e, v.rs1, v.rs2, v.rd, v.ctl);
        end
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        rst = 1'b1; InstrnD = '0; PCD = '0; PCplus4D = '0;
        FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;

        // Reset with a jal in D must still leave a bubble
        v = bubble(mk("reset_init", 32'h008000EF, 32'h80, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(v);
        checkOutput(v);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            v = mk("fill", 32'h0, 32'h0, 0, 1, 5'(i), 32'h100 + 32'(i), 1, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(v);
        end
        v = mk("fill_readback", encAdd(5'd1, 5'd5, 5'd5), 32'h40, 0, 0, 0, 0,
               0, 32'h105, 32'h105, 0, 5, 5, 1, 10'b1_00_0_0_0_000_0);
        applyStimulus(v);
        checkOutput(v);

        // Second reset clears the filled registers even with a writeback on the same edge
        rst = 1'b1;
        v = bubble(mk("reset_with_wb", 32'h008000EF, 32'h44, 0, 1, 9, 32'hDEAD, 1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(v);
        checkOutput(v);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            v = mk($sformatf("reset_read_x%0d", i), encAdd(5'd1, 5'(i), 5'(i)), 32'h400 + 32'(4*i),
                   0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(i), 1, 10'b1_00_0_0_0_000_0);
            applyStimulus(v);
            checkOutput(v);
        end

        //                 name          instr         pcd       fl wr rdW  resW          ci rd1           rd2           imm           rs1 rs2 rd  ctl
        vecs.push_back(mk("wr_x5",       32'h00000000, 32'h010,  0, 1, 5,  32'hAA,       1, 32'h0,        32'h0,        32'h0,        0,  0,  0,  10'b0_00_0_0_0_000_0));
        vecs.push_back(mk("addi",        32'h00528313, 32'h014,  0, 0, 0,  32'h0,        1, 32'hAA,       32'hAA,       32'h5,        5,  5,  6,  10'b1_00_0_0_0_000_1));
        vecs.push_back(mk("sub_bypass",  32'h40738433, 32'h018,  0, 1, 7,  32'h1234,     0, 32'h1234,     32'h1234,     32'h0,        7,  7,  8,  10'b1_00_0_0_0_001_0));
        vecs.push_back(mk("sw_pos",      32'h00532423, 32'h01C,  0, 0, 0,  32'h0,        1, 32'h0,        32'hAA,       32'h8,        6,  5,  8,  10'b0_00_1_0_0_000_1));
        vecs.push_back(mk("sw_neg",      32'hFE502E23, 32'h020,  0, 0, 0,  32'h0,        1, 32'h0,        32'hAA,       32'hFFFFFFFC, 0,  5,  28, 10'b0_00_1_0_0_000_1));
        vecs.push_back(mk("beq",         32'hFE000EE3, 32'h100,  0, 0, 0,  32'h0,        1, 32'h0,        32'h0,        32'hFFFFFFFC, 0,  0,  29, 10'b0_00_0_0_1_001_0));
        vecs.push_back(bubble(mk("beq_flush", 32'hFE000EE3, 32'h100, 1, 0, 0, 32'h0,   1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("jal",         32'h008000EF, 32'h200,  0, 0, 0,  32'h0,        1, 32'h0,        32'h0,        32'h8,        0,  8,  1,  10'b1_10_0_1_0_000_0));
        vecs.push_back(mk("lw",          32'hFF82A503, 32'h204,  0, 0, 0,  32'h0,        1, 32'hAA,       32'h0,        32'hFFFFFFF8, 5,  24, 10, 10'b1_01_0_0_0_000_1));
        vecs.push_back(mk("ori",         32'h0F02E193, 32'h208,  0, 0, 0,  32'h0,        1, 32'hAA,       32'h0,        32'hF0,       5,  16, 3,  10'b1_00_0_0_0_011_1));
        vecs.push_back(mk("and",         32'h0062F233, 32'h20C,  0, 0, 0,  32'h0,        0, 32'hAA,       32'h0,        32'h0,        5,  6,  4,  10'b1_00_0_0_0_010_0));
        vecs.push_back(mk("slt",         32'h0062A233, 32'h210,  0, 0, 0,  32'h0,        0, 32'hAA,       32'h0,        32'h0,        5,  6,  4,  10'b1_00_0_0_0_101_0));
        vecs.push_back(mk("xor_default", 32'h0062C233, 32'h214,  0, 0, 0,  32'h0,        0, 32'hAA,       32'h0,        32'h0,        5,  6,  4,  10'b1_00_0_0_0_000_0));
        vecs.push_back(mk("addi_bit30",  32'hC0028093, 32'h218,  0, 0, 0,  32'h0,        1, 32'hAA,       32'h0,        32'hFFFFFC00, 5,  0,  1,  10'b1_00_0_0_0_000_1));
        vecs.push_back(mk("wr_x0",       32'h000000B3, 32'h21C,  0, 1, 0,  32'hFFFF,     0, 32'h0,        32'h0,        32'h0,        0,  0,  1,  10'b1_00_0_0_0_000_0));
        vecs.push_back(mk("rd_x0",       32'h000000B3, 32'h220,  0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        0,  0,  1,  10'b1_00_0_0_0_000_0));
        vecs.push_back(mk("illegal",     32'hFFFFFFFF, 32'h224,  0, 0, 0,  32'h0,        1, 32'h0,        32'h0,        32'h0,        31, 31, 31, 10'b0_00_0_0_0_000_0));
        vecs.push_back(bubble(mk("flush_wr_x12", 32'h00528313, 32'h228, 1, 1, 12, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("rd_x12",      32'h000600B3, 32'h22C,  0, 0, 0,  32'h0,        0, 32'h55,       32'h0,        32'h0,        12, 0,  1,  10'b1_00_0_0_0_000_0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
